sd_init: RTL
============

# sd_init

SPI-mode SD card initialisation sequencer. Sits beside `sdcmd` in the `sdspi` core and sequences it: it clocks out the power-up dummy bytes itself with CS high, then issues CMD0, CMD8, the CMD55/ACMD41 loop and, optionally, CMD16 through `sdcmd`'s `w_cmd`/`busy` handshake. It reports done, card version or a sticky error code. While `spi_own` is high, the top level routes the SPI master to this block; otherwise the SPI master belongs to `sdcmd`.

## Interface
Parameters:
- `POWERUP_BYTES`, 10: 0xFF bytes sent with CS high before CMD0 (minimum 74 clocks).
- `CMD0_RETRIES`, 8: CMD0 attempts before error.
- `ACMD41_RETRIES`, 1000: CMD55/ACMD41 pairs before timeout; 16-bit counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins initialisation; honoured only in IDLE, DONE or ERROR.
- `done` out 1: card initialised; held until next `start`/`reset`.
- `error` out 1: sticky failure flag.
- `error_code` out 4: 0 none, 1 CMD0 exhausted, 2 CMD8 bad response, 3 ACMD41 timeout, 4 unexpected R1, 5 CMD16 reject.
- `card_v2` out 1: CMD8 accepted (SD v2+ card).
- `busy` out 1: high outside IDLE/DONE/ERROR.
- `w_cmd` out 1: command strobe to `sdcmd`.
- `command` out 48: frame to `sdcmd`; held stable from strobe until `sdcmd` busy falls.
- `response` in 40: from `sdcmd`; R1 in [39:32].
- `cmd_busy` in 1: `sdcmd` busy.
- `spi_own` out 1: this block drives the SPI master.
- `spi_w` out 1: SPI byte strobe during power-up.
- `spi_data_out` out 8: constant 0xFF.
- `cs_spi` out 1: 1 during power-up.
- `spi_busy` in 1: SPI master busy.

## Operation
- States: IDLE, PWR_SEND, PWR_GAP, PWR_WAIT, CMD_ISSUE, CMD_GAP, CMD_WAIT, EVAL, DONE, ERROR. A step register holds the active command: CMD0, CMD8, CMD55, ACMD41, CMD16.
- IDLE + `start` → PWR_SEND. Clears `done`, `error`, `error_code`, `card_v2`, byte counter and retry counter.
- Power-up: PWR_SEND pulses `spi_w` for one cycle, then PWR_GAP lasts one cycle, then PWR_WAIT holds until `spi_busy`=0. The byte counter increments; after `POWERUP_BYTES` bytes the block drops `spi_own` and goes to CMD_ISSUE with step CMD0.
- Command frames:
  - CMD0: 40_00000000_95
  - CMD8: 48_000001AA_87
  - CMD55: 77_00000000_01
  - ACMD41: 69_40000000_01 if `card_v2`, else 69_00000000_01
  - CMD16: 50_00000200_01
- Command handshake: CMD_ISSUE waits for `cmd_busy`=0, then pulses `w_cmd` for one cycle. CMD_GAP lasts one cycle. CMD_WAIT holds until `cmd_busy`=0. EVAL then samples `response`.
- EVAL, with R1 = `response[39:32]`:
  - CMD0: R1=0x01 → CMD8 and retry counter cleared. Otherwise retry+1; if retry reaches `CMD0_RETRIES` → ERROR code 1, else reissue CMD0.
  - CMD8: R1=0x01, `response[11:8]`=1 and `response[7:0]`=0xAA → `card_v2`=1, go to CMD55. R1=0x05 (illegal command) → `card_v2`=0, go to CMD55. Otherwise ERROR code 2.
  - CMD55: R1 ∈ {0x00, 0x01} → ACMD41. Otherwise ERROR code 4.
  - ACMD41: R1=0x00 → CMD16 if enabled, else DONE. R1=0x01 → retry+1; if retry reaches `ACMD41_RETRIES` → ERROR code 3, else CMD55. Otherwise ERROR code 4.
  - CMD16: R1=0x00 → DONE. Otherwise ERROR code 5.
- DONE and ERROR are terminal. `start` in either state re-enters PWR_SEND.

## Timing
- Reset values: every output 0 except `spi_data_out`=0xFF; state IDLE.
- `reset` mid-sequence aborts on the next edge. A `sdcmd` transfer in flight completes unobserved; the next `start` waits in CMD_ISSUE for `cmd_busy`=0.
- `busy` rises the cycle after `start`.
- `done`/`error` rise the cycle after the final EVAL.
- Power-up cost is `POWERUP_BYTES` × (SPI byte time + 2) cycles.
- `start` arriving while `busy`=1 is ignored.
- Retry compare uses a 16-bit counter equal to the parameter. A parameter value of 0 is treated as 1.
- `cs_spi`=1 only while `spi_own`=1.

## Configuration
- `SD_INIT_CMD16_EN` defined: after ACMD41 returns 0x00 and `card_v2`=0, issue CMD16 (block length 512). A v2 card skips CMD16.
- `SD_INIT_CMD16_EN` undefined: the CMD16 step, its frame and error code 5 are absent; ACMD41 R1=0x00 → DONE.

## Test plan
- v2 card model: CMD0→01, CMD8→01_000001AA, ACMD41→01 twice then 00 → `done`=1, `card_v2`=1, 3 CMD55/ACMD41 pairs, exactly 10 power-up `spi_w` pulses with `cs_spi`=1.
- v1 card: CMD8→05, ACMD41→00 with CMD16 enabled → CMD16 frame 50_00000200_01 issued, CMD16→00 → `done`=1, `card_v2`=0.
- CMD0 always 0xFF, `CMD0_RETRIES`=8 → 8 CMD0 strobes, then `error`=1, `error_code`=1.
- ACMD41 always 01, `ACMD41_RETRIES`=4 → 4 pairs, then `error_code`=3.
- CMD8 echo 0x55 → `error_code`=2. Then pulse `start` with a good card → `error` clears, `done`=1.
- `reset` during the 3rd power-up byte → all outputs at reset values the next cycle. A subsequent `start` restarts with 10 fresh bytes.

Source files
------------

// File: rtl/sd_init.sv
// SPI-mode SD card initialisation sequencer.
// Sends the power-up 0xFF bytes with CS high, then walks CMD0, CMD8, the CMD55/ACMD41 loop and,
// when SD_INIT_CMD16_EN is defined, CMD16 for v1 cards, through the sdcmd strobe/busy handshake.
// Optional feature macro: SD_INIT_CMD16_EN.
module sd_init #(
  parameter int unsigned POWERUP_BYTES  = 10,
  parameter int unsigned CMD0_RETRIES   = 8,
  parameter int unsigned ACMD41_RETRIES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_done,
  output logic        o_error,
  output logic [3:0]  o_error_code,
  output logic        o_card_v2,
  output logic        o_busy,
  output logic        o_w_cmd,
  output logic [47:0] o_command,
  input  logic [39:0] i_response,
  input  logic        i_cmd_busy,
  output logic        o_spi_own,
  output logic        o_spi_w,
  output logic [7:0]  o_spi_data_out,
  output logic        o_cs_spi,
  input  logic        i_spi_busy
);

  // A zero limit would never match an incremented counter, so it is treated as one.
  localparam logic [15:0] PwrBytes  = (POWERUP_BYTES == 0) ? 16'd1 : 16'(POWERUP_BYTES);
  localparam logic [15:0] Cmd0Lim   = (CMD0_RETRIES == 0) ? 16'd1 : 16'(CMD0_RETRIES);
  localparam logic [15:0] Acmd41Lim = (ACMD41_RETRIES == 0) ? 16'd1 : 16'(ACMD41_RETRIES);

  localparam logic [47:0] FrameCmd0    = 48'h40_0000_0000_95;
  localparam logic [47:0] FrameCmd8    = 48'h48_0000_01AA_87;
  localparam logic [47:0] FrameCmd55   = 48'h77_0000_0000_01;
  localparam logic [47:0] FrameAcmd41  = 48'h69_0000_0000_01;
  localparam logic [47:0] FrameAcmd41H = 48'h69_4000_0000_01;
`ifdef SD_INIT_CMD16_EN
  localparam logic [47:0] FrameCmd16   = 48'h50_0000_0200_01;
`endif

  typedef enum logic [3:0] {
    StIdle, StPwrSend, StPwrGap, StPwrWait, StCmdIssue,
    StCmdGap, StCmdWait, StEval, StDone, StError
  } state_e;

  typedef enum logic [2:0] {
    StepCmd0, StepCmd8, StepCmd55,
`ifdef SD_INIT_CMD16_EN
    StepCmd16,
`endif
    StepAcmd41
  } step_e;

  state_e      r_state, w_state_d;
  step_e       r_step, w_step_d;
  logic [15:0] r_byte_cnt, w_byte_cnt_d;
  logic [15:0] r_retry, w_retry_d;
  logic        r_done, w_done_d;
  logic        r_error, w_error_d;
  logic [3:0]  r_error_code, w_error_code_d;
  logic        r_card_v2, w_card_v2_d;
  logic        w_cmd_strobe;
  logic [7:0]  w_r1;
  logic [15:0] w_byte_inc;
  logic [15:0] w_retry_inc;
  logic [47:0] w_frame;
  logic        w_unused_resp;

  assign w_r1          = i_response[39:32];
  assign w_byte_inc    = r_byte_cnt + 16'd1;
  assign w_retry_inc   = r_retry + 16'd1;
  assign w_unused_resp = ^i_response[31:12];

  // State and status registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_step       <= StepCmd0;
      r_byte_cnt   <= 16'd0;
      r_retry      <= 16'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= 4'd0;
      r_card_v2    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_step       <= w_step_d;
      r_byte_cnt   <= w_byte_cnt_d;
      r_retry      <= w_retry_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_error_code <= w_error_code_d;
      r_card_v2    <= w_card_v2_d;
    end
  end

  // Next-state logic: power-up bytes, command handshake and response evaluation.
  always_comb begin
    w_state_d      = r_state;
    w_step_d       = r_step;
    w_byte_cnt_d   = r_byte_cnt;
    w_retry_d      = r_retry;
    w_done_d       = r_done;
    w_error_d      = r_error;
    w_error_code_d = r_error_code;
    w_card_v2_d    = r_card_v2;
    w_cmd_strobe   = 1'b0;
    unique case (r_state)
      StIdle, StDone, StError: begin
        if (i_start) begin
          w_state_d      = StPwrSend;
          w_done_d       = 1'b0;
          w_error_d      = 1'b0;
          w_error_code_d = 4'd0;
          w_card_v2_d    = 1'b0;
          w_byte_cnt_d   = 16'd0;
          w_retry_d      = 16'd0;
        end
      end
      StPwrSend: w_state_d = StPwrGap;
      // The gap gives the SPI master a cycle to raise busy before it is polled.
      StPwrGap:  w_state_d = StPwrWait;
      StPwrWait: begin
        if (!i_spi_busy) begin
          w_byte_cnt_d = w_byte_inc;
          if (w_byte_inc == PwrBytes) begin
            w_state_d = StCmdIssue;
            w_step_d  = StepCmd0;
          end else begin
            w_state_d = StPwrSend;
          end
        end
      end
      StCmdIssue: begin
        // A transfer left over from an aborted run must drain before a new strobe.
        if (!i_cmd_busy) begin
          w_cmd_strobe = 1'b1;
          w_state_d    = StCmdGap;
        end
      end
      StCmdGap:  w_state_d = StCmdWait;
      StCmdWait: begin
        if (!i_cmd_busy) w_state_d = StEval;
      end
      StEval: begin
        w_state_d = StCmdIssue;
        case (r_step)
          StepCmd0: begin
            if (w_r1 == 8'h01) begin
              w_step_d  = StepCmd8;
              w_retry_d = 16'd0;
            end else begin
              w_retry_d = w_retry_inc;
              if (w_retry_inc == Cmd0Lim) begin
                w_state_d      = StError;
                w_error_d      = 1'b1;
                w_error_code_d = 4'd1;
              end
            end
          end
          StepCmd8: begin
            if (w_r1 == 8'h01 && i_response[11:8] == 4'h1 && i_response[7:0] == 8'hAA) begin
              w_card_v2_d = 1'b1;
              w_step_d    = StepCmd55;
            end else if (w_r1 == 8'h05) begin
              w_card_v2_d = 1'b0;
              w_step_d    = StepCmd55;
            end else begin
              w_state_d      = StError;
              w_error_d      = 1'b1;
              w_error_code_d = 4'd2;
            end
          end
          StepCmd55: begin
            if (w_r1 == 8'h00 || w_r1 == 8'h01) begin
              w_step_d = StepAcmd41;
            end else begin
              w_state_d      = StError;
              w_error_d      = 1'b1;
              w_error_code_d = 4'd4;
            end
          end
          StepAcmd41: begin
            if (w_r1 == 8'h00) begin
`ifdef SD_INIT_CMD16_EN
              // Only v1 cards need the block length forced to 512.
              if (!r_card_v2) begin
                w_step_d = StepCmd16;
              end else begin
                w_state_d = StDone;
                w_done_d  = 1'b1;
              end
`else
              w_state_d = StDone;
              w_done_d  = 1'b1;
`endif
            end else if (w_r1 == 8'h01) begin
              w_retry_d = w_retry_inc;
              if (w_retry_inc == Acmd41Lim) begin
                w_state_d      = StError;
                w_error_d      = 1'b1;
                w_error_code_d = 4'd3;
              end else begin
                w_step_d = StepCmd55;
              end
            end else begin
              w_state_d      = StError;
              w_error_d      = 1'b1;
              w_error_code_d = 4'd4;
            end
          end
`ifdef SD_INIT_CMD16_EN
          StepCmd16: begin
            if (w_r1 == 8'h00) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
            end else begin
              w_state_d      = StError;
              w_error_d      = 1'b1;
              w_error_code_d = 4'd5;
            end
          end
`endif
          default: begin
            w_state_d      = StError;
            w_error_d      = 1'b1;
            w_error_code_d = 4'd4;
          end
        endcase
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Command frame for the active step; driven only while a command is in progress.
  always_comb begin
    w_frame = 48'h0;
    case (r_step)
      StepCmd0:   w_frame = FrameCmd0;
      StepCmd8:   w_frame = FrameCmd8;
      StepCmd55:  w_frame = FrameCmd55;
      StepAcmd41: w_frame = r_card_v2 ? FrameAcmd41H : FrameAcmd41;
`ifdef SD_INIT_CMD16_EN
      StepCmd16:  w_frame = FrameCmd16;
`endif
      default:    w_frame = 48'h0;
    endcase
    o_command = (r_state inside {StCmdIssue, StCmdGap, StCmdWait, StEval}) ? w_frame : 48'h0;
  end

  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_error_code   = r_error_code;
  assign o_card_v2      = r_card_v2;
  assign o_busy         = !(r_state inside {StIdle, StDone, StError});
  assign o_w_cmd        = w_cmd_strobe;
  assign o_spi_own      = r_state inside {StPwrSend, StPwrGap, StPwrWait};
  assign o_spi_w        = (r_state == StPwrSend);
  assign o_spi_data_out = 8'hFF;
  assign o_cs_spi       = o_spi_own;

endmodule
